// File: rtl/otter_rf_pkg.sv
// -----------------------------------------------------------------------------
// otter_rf_pkg
// Shared register-file write types for the writeback / MDU write arbiter.
//   REG_ADDR_W : register address width
//   XLEN       : register data width
//   rf_wr_t    : one pending register-file write {addr, data}
// -----------------------------------------------------------------------------
package otter_rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_wr_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter_if
// Bundles the WB request, MDU handshake, register-file write port and decode
// hazard-check signals of rf_write_arbiter.
//   slave  : the arbiter side (consumes requests, drives RF write and status)
//   master : the environment side (pipeline, MDU, decode)
// -----------------------------------------------------------------------------
interface rf_write_arbiter_if;
  import otter_rf_pkg::*;

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic                  wb_stall;
  logic                  mdu_valid;
  logic [REG_ADDR_W-1:0] mdu_addr;
  logic [XLEN-1:0]       mdu_data;
  logic                  mdu_ready;
  logic                  rf_w_en;
  logic [REG_ADDR_W-1:0] rf_w_addr;
  logic [XLEN-1:0]       rf_w_data;
  logic [REG_ADDR_W-1:0] chk_addr1;
  logic [REG_ADDR_W-1:0] chk_addr2;
  logic                  hazard1;
  logic                  hazard2;
  logic                  pend_busy;

  modport slave (
    input  wb_valid, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
           chk_addr1, chk_addr2,
    output wb_stall, mdu_ready, rf_w_en, rf_w_addr, rf_w_data,
           hazard1, hazard2, pend_busy
  );

  modport master (
    output wb_valid, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
           chk_addr1, chk_addr2,
    input  wb_stall, mdu_ready, rf_w_en, rf_w_addr, rf_w_data,
           hazard1, hazard2, pend_busy
  );
endinterface

// File: rtl/rf_wr_fifo.sv
// -----------------------------------------------------------------------------
// rf_wr_fifo
// Small in-order queue of pending register-file writes.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push       : enqueue i_wdata (ignored when full)
//   i_pop        : dequeue head (ignored when empty)
//   o_head       : oldest entry
//   o_full/o_empty/o_count : occupancy
//   o_vld/o_addr : per-slot valid and destination, for hazard comparison
// -----------------------------------------------------------------------------
module rf_wr_fifo
  import otter_rf_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  rf_wr_t                i_wdata,
  input  logic                  i_pop,
  output rf_wr_t                o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CNT_W-1:0]      o_count,
  output logic [DEPTH-1:0]      o_vld,
  output logic [REG_ADDR_W-1:0] o_addr [DEPTH]
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_vld;
  rf_wr_t           r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == CNT_W'(0));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_vld   = r_vld;

  // Per-slot destination address view for the hazard comparators.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_addr[i] = r_mem[i].addr;
    end
  end

  // Pointer, occupancy and slot-valid state; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= PTR_W'(0);
      r_wr_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
      r_vld    <= DEPTH'(0);
    end else begin
      // Push and pop never target the same slot: pop needs !empty, push needs !full.
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
        r_vld[r_rd_ptr] <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        r_vld[r_wr_ptr] <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; slot contents are only meaningful while r_vld is set.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register file write port between WB (priority, zero latency) and
// queued MDU results, with a starvation limit and decode hazard reporting.
//   clk, rst : clock, synchronous active-high reset (all outputs 0 while high)
//   bus      : rf_write_arbiter_if.slave (WB, MDU, RF write, hazard signals)
// Parameters: DEPTH (MDU queue entries, power of two >= 2),
//             MAX_WAIT (cycles a queued result may wait before WB is stalled).
// -----------------------------------------------------------------------------
module rf_write_arbiter
  import otter_rf_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  rf_write_arbiter_if.slave  bus
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0]     r_wait_cnt;
  rf_wr_t                w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic [DEPTH-1:0]      w_vld;
  logic [REG_ADDR_W-1:0] w_addr [DEPTH];
  logic                  w_push;
  logic                  w_pop;
  logic                  w_grant_vld;
  rf_wr_t                w_grant;
  logic                  w_wb_stall;
  logic                  w_haz1;
  logic                  w_haz2;

  // Ready has no same-cycle pop credit; writes to x0 are acknowledged but dropped.
  assign bus.mdu_ready = !rst && !w_full;
  assign w_push        = bus.mdu_valid && bus.mdu_ready && (bus.mdu_addr != 5'd0);

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_wdata ({bus.mdu_addr, bus.mdu_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_vld   (w_vld),
    .o_addr  (w_addr)
  );

  // Write-port grant: starved queue, then WB, then opportunistic queue drain.
  always_comb begin
    w_pop       = 1'b0;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_wb_stall  = 1'b0;
    if (rst) begin
      w_grant_vld = 1'b0;
    end else if (!w_empty && (r_wait_cnt == WAIT_LIMIT)) begin
      w_pop       = 1'b1;
      w_grant_vld = 1'b1;
      w_grant     = w_head;
      w_wb_stall  = bus.wb_valid;
    end else if (bus.wb_valid) begin
      w_grant_vld = 1'b1;
      w_grant     = {bus.wb_addr, bus.wb_data};
    end else if (!w_empty) begin
      w_pop       = 1'b1;
      w_grant_vld = 1'b1;
      w_grant     = w_head;
    end else begin
      w_grant_vld = 1'b0;
    end
  end

  // A grant to x0 still consumes the slot but never strobes the register file.
  assign bus.rf_w_en   = w_grant_vld && (w_grant.addr != 5'd0);
  assign bus.rf_w_addr = w_grant.addr;
  assign bus.rf_w_data = w_grant.data;
  assign bus.wb_stall  = w_wb_stall;
  assign bus.pend_busy = !rst && (w_count != CNT_W'(0));

  // Starvation counter: counts cycles the queue head has been passed over.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= WAIT_W'(0);
    end else if (w_pop || w_empty) begin
      r_wait_cnt <= WAIT_W'(0);
    end else if (r_wait_cnt != WAIT_LIMIT) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // Hazards cover every queued entry including one popping now; an entry accepted now is not yet queued.
  always_comb begin
    w_haz1 = 1'b0;
    w_haz2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_haz1 = w_haz1 | (w_vld[i] && (w_addr[i] == bus.chk_addr1));
      w_haz2 = w_haz2 | (w_vld[i] && (w_addr[i] == bus.chk_addr2));
    end
  end

  assign bus.hazard1 = !rst && w_haz1 && (bus.chk_addr1 != 5'd0);
  assign bus.hazard2 = !rst && w_haz2 && (bus.chk_addr2 != 5'd0);
endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
// Directed bench for rf_write_arbiter: expected register-file writes are queued
// as stimulus is applied and matched in order against every RF write strobe.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;
  import otter_rf_pkg::*;

  logic   clk;
  logic   rst;
  int     n_tests;
  int     n_fail;
  rf_wr_t sb_q [$];

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    rf_wr_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Scoreboard: each RF write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.rf_w_en) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra_wr", 64'(bus.rf_w_en), 64'd0);
      end else begin
        rf_wr_t e;
        e = sb_q.pop_front();
        chk("sb_addr", 64'(bus.rf_w_addr), 64'(e.addr));
        chk("sb_data", 64'(bus.rf_w_data), 64'(e.data));
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
    bus.mdu_valid = 1'b0; bus.mdu_addr = 5'd0; bus.mdu_data = 32'd0;
    bus.chk_addr1 = 5'd0; bus.chk_addr2 = 5'd0;

    // Reset state
    step(); smp();
    chk("rst_w_en", 64'(bus.rf_w_en), 64'd0);
    chk("rst_ready", 64'(bus.mdu_ready), 64'd0);
    chk("rst_busy", 64'(bus.pend_busy), 64'd0);
    step(); rst = 1'b0; smp();
    chk("post_rst_ready", 64'(bus.mdu_ready), 64'd1);
    chk("post_rst_busy", 64'(bus.pend_busy), 64'd0);
    chk("post_rst_w_en", 64'(bus.rf_w_en), 64'd0);

    // 1. WB only: same-cycle write
    step(); bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    smp();
    chk("t1_w_en", 64'(bus.rf_w_en), 64'd1);
    chk("t1_addr", 64'(bus.rf_w_addr), 64'd5);
    chk("t1_stall", 64'(bus.wb_stall), 64'd0);

    // 2. MDU only: written the cycle after acceptance
    step(); bus.wb_valid = 1'b0; bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd7; bus.mdu_data = 32'd42;
    smp();
    chk("t2_ready", 64'(bus.mdu_ready), 64'd1);
    chk("t2_no_wr_yet", 64'(bus.rf_w_en), 64'd0);
    expect_wr(5'd7, 32'd42);
    step(); bus.mdu_valid = 1'b0; smp();
    chk("t2_w_en", 64'(bus.rf_w_en), 64'd1);
    chk("t2_busy", 64'(bus.pend_busy), 64'd1);
    step(); smp();
    chk("t2_busy_clr", 64'(bus.pend_busy), 64'd0);

    // 3. Starvation: queued result forces a WB stall after MAX_WAIT cycles
    step(); bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd9; bus.mdu_data = 32'h99;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'd100;
    expect_wr(5'd3, 32'd100);
    smp();
    chk("t3_ready", 64'(bus.mdu_ready), 64'd1);
    chk("t3_stall0", 64'(bus.wb_stall), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      step(); bus.mdu_valid = 1'b0; bus.wb_data = 32'(100 + k);
      expect_wr(5'd3, 32'(100 + k));
      smp();
      chk("t3_nostall", 64'(bus.wb_stall), 64'd0);
      chk("t3_busy", 64'(bus.pend_busy), 64'd1);
    end
    step(); bus.wb_data = 32'd105;
    expect_wr(5'd9, 32'h99);
    smp();
    chk("t3_stall", 64'(bus.wb_stall), 64'd1);
    step(); expect_wr(5'd3, 32'd105); smp();
    chk("t3_stall_drop", 64'(bus.wb_stall), 64'd0);
    chk("t3_busy_clr", 64'(bus.pend_busy), 64'd0);

    // 4. Full queue: third offer back-pressured, all three written in order
    step(); bus.wb_addr = 5'd4; bus.wb_data = 32'd200;
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd10; bus.mdu_data = 32'hA;
    expect_wr(5'd4, 32'd200);
    smp(); chk("t4_ready0", 64'(bus.mdu_ready), 64'd1);
    step(); bus.wb_data = 32'd201; bus.mdu_addr = 5'd11; bus.mdu_data = 32'hB;
    expect_wr(5'd4, 32'd201);
    smp(); chk("t4_ready1", 64'(bus.mdu_ready), 64'd1);
    step(); bus.wb_data = 32'd202; bus.mdu_addr = 5'd13; bus.mdu_data = 32'hC;
    expect_wr(5'd4, 32'd202);
    smp(); chk("t4_full", 64'(bus.mdu_ready), 64'd0);
    step(); bus.wb_valid = 1'b0; expect_wr(5'd10, 32'hA);
    smp(); chk("t4_full_pop", 64'(bus.mdu_ready), 64'd0);
    step(); expect_wr(5'd11, 32'hB);
    smp(); chk("t4_ready_again", 64'(bus.mdu_ready), 64'd1);
    step(); bus.mdu_valid = 1'b0; expect_wr(5'd13, 32'hC);
    smp(); chk("t4_busy", 64'(bus.pend_busy), 64'd1);
    step(); smp(); chk("t4_busy_clr", 64'(bus.pend_busy), 64'd0);

    // 5. Hazard against a queued result
    step(); bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd12; bus.mdu_data = 32'h12;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'd300;
    bus.chk_addr1 = 5'd12; bus.chk_addr2 = 5'd0;
    expect_wr(5'd6, 32'd300);
    smp(); chk("t5_haz_accept", 64'(bus.hazard1), 64'd0);
    step(); bus.mdu_valid = 1'b0; bus.wb_valid = 1'b0; expect_wr(5'd12, 32'h12);
    smp();
    chk("t5_haz1", 64'(bus.hazard1), 64'd1);
    chk("t5_haz2_x0", 64'(bus.hazard2), 64'd0);
    bus.chk_addr2 = 5'd12; #1;
    chk("t5_haz2", 64'(bus.hazard2), 64'd1);
    step(); bus.chk_addr2 = 5'd0; smp();
    chk("t5_haz1_drop", 64'(bus.hazard1), 64'd0);

    // MDU result to x0 is accepted but never queued; WB to x0 never strobes
    step(); bus.chk_addr1 = 5'd0; bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd0; bus.mdu_data = 32'h55;
    smp(); chk("x0_ready", 64'(bus.mdu_ready), 64'd1);
    step(); bus.mdu_valid = 1'b0; smp();
    chk("x0_not_queued", 64'(bus.pend_busy), 64'd0);
    chk("x0_no_wr", 64'(bus.rf_w_en), 64'd0);
    step(); bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'd7; smp();
    chk("wb_x0_w_en", 64'(bus.rf_w_en), 64'd0);
    chk("wb_x0_stall", 64'(bus.wb_stall), 64'd0);

    // 6. Reset with two entries queued: they are discarded
    step(); bus.wb_addr = 5'd1; bus.wb_data = 32'd500;
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd20; bus.mdu_data = 32'h20;
    expect_wr(5'd1, 32'd500);
    smp();
    step(); bus.wb_data = 32'd501; bus.mdu_addr = 5'd21; bus.mdu_data = 32'h21;
    expect_wr(5'd1, 32'd501);
    smp(); chk("t6_busy", 64'(bus.pend_busy), 64'd1);
    step(); rst = 1'b1; bus.mdu_valid = 1'b0; smp();
    chk("t6_rst_w_en", 64'(bus.rf_w_en), 64'd0);
    chk("t6_rst_ready", 64'(bus.mdu_ready), 64'd0);
    chk("t6_rst_stall", 64'(bus.wb_stall), 64'd0);
    step(); rst = 1'b0; bus.wb_valid = 1'b0; smp();
    chk("t6_busy_clr", 64'(bus.pend_busy), 64'd0);
    chk("t6_w_en", 64'(bus.rf_w_en), 64'd0);
    chk("t6_ready", 64'(bus.mdu_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step(); smp();
      chk("t6_dropped", 64'(bus.rf_w_en), 64'd0);
    end

    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
